sd_req_arbiter: RTL

- Shares the single SD-card request channel of the SPI user I/O block between NREQ independent drive requesters, for example floppy and hard-disk controllers.
- Each requester presents a sector request: read/write plus an LBA. The arbiter grants one request at a time, round-robin, and drives that requester's slot on the sd_rd/sd_wr vectors with a held sd_lba.
- It tracks the sd_ack handshake to completion, routes byte strobes and write data for the granted requester, and reports done or timeout per requester.

---
 rtl/sd_req_arbiter_if.sv | 34 +++
 rtl/sd_req_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sd_req_arbiter_if.sv
// Requester-side and SD-side signal bundle of sd_req_arbiter.
// The master modport is the arbiter's view; slave is the surrounding logic.
interface sd_req_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req_rd;
  logic [NREQ-1:0]    req_wr;
  logic [32*NREQ-1:0] req_lba;
  logic [8*NREQ-1:0]  req_din;
  logic [NREQ-1:0]    req_done;
  logic [NREQ-1:0]    req_err;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    req_dout_strobe;
  logic [NREQ-1:0]    req_din_strobe;
  logic [31:0]        sd_lba;
  logic [NREQ-1:0]    sd_rd;
  logic [NREQ-1:0]    sd_wr;
  logic [7:0]         sd_din;
  logic               sd_ack;
  logic               sd_dout_strobe;
  logic               sd_din_strobe;

  modport master (
    input  req_rd, req_wr, req_lba, req_din, sd_ack, sd_dout_strobe, sd_din_strobe,
    output req_done, req_err, grant, req_dout_strobe, req_din_strobe,
    output sd_lba, sd_rd, sd_wr, sd_din
  );

  modport slave (
    output req_rd, req_wr, req_lba, req_din, sd_ack, sd_dout_strobe, sd_din_strobe,
    input  req_done, req_err, grant, req_dout_strobe, req_din_strobe,
    input  sd_lba, sd_rd, sd_wr, sd_din
  );
endinterface

// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter sharing one SD sector-request channel between NREQ
// requesters, with ack tracking, per-requester strobe routing and timeout.
module sd_req_arbiter #(
  parameter int          NREQ    = 2,
  parameter logic [31:0] TIMEOUT = 32'd2000000
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  sd_req_arbiter_if.master bus
);

  localparam int              IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [31:0]     TO_LAST   = TIMEOUT - 32'd1;
  localparam logic [IW-1:0]   LAST_INIT = IW'(NREQ - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_XFER     = 3'd3,
    S_DONE     = 3'd4,
    S_ABORT    = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   last_idx_q, last_idx_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [31:0]     lba_q, lba_d;
  logic [NREQ-1:0] rd_q, rd_d;
  logic [NREQ-1:0] wr_q, wr_d;
  logic            op_rd_q, op_rd_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] err_q, err_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            mask_vld_q, mask_vld_d;
  logic            ack_meta_q, ack_s_q;

  logic [NREQ-1:0] pending_s;
  logic [IW-1:0]   sel_s;
  logic            found_s;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : (c + 32'd1);
  endfunction

  // sd_ack may come from another clock domain
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= bus.sd_ack;
      ack_s_q    <= ack_meta_q;
    end
  end

  // Round-robin search starting just after the last served requester;
  // the requester that just finished is hidden for one IDLE cycle.
  always_comb begin
    int cand;
    pending_s = (bus.req_rd | bus.req_wr) & ~(mask_vld_q ? onehot(idx_q) : '0);
    found_s   = 1'b0;
    sel_s     = '0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand    = (int'(last_idx_q) + k) % NREQ;
      sel_s   = (!found_s && pending_s[IW'(cand)]) ? IW'(cand) : sel_s;
      found_s = found_s | pending_s[IW'(cand)];
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    grant_d    = grant_q;
    lba_d      = lba_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    op_rd_d    = op_rd_q;
    done_d     = '0;
    err_d      = '0;
    cnt_d      = cnt_q;
    mask_vld_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          idx_d   = sel_s;
          grant_d = onehot(sel_s);
          lba_d   = bus.req_lba[{sel_s, 5'd0} +: 32];
          op_rd_d = bus.req_rd[sel_s];
          state_d = S_ISSUE;
        end else begin
          grant_d = '0;
        end
      end
      S_ISSUE: begin
        rd_d    = op_rd_q ? onehot(idx_q) : '0;
        wr_d    = op_rd_q ? '0 : onehot(idx_q);
        cnt_d   = 32'd0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ack_s_q) begin
          rd_d    = '0;
          wr_d    = '0;
          cnt_d   = 32'd0;
          state_d = S_XFER;
        end else if (cnt_q == TO_LAST) begin
          rd_d    = '0;
          wr_d    = '0;
          err_d   = onehot(idx_q);
          state_d = S_ABORT;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      S_XFER: begin
        if (!ack_s_q) begin
          done_d  = onehot(idx_q);
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = onehot(idx_q);
          state_d = S_ABORT;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      S_DONE: begin
        grant_d    = '0;
        last_idx_d = idx_q;
        mask_vld_d = 1'b1;
        state_d    = S_IDLE;
      end
      S_ABORT: begin
        rd_d       = '0;
        wr_d       = '0;
        grant_d    = '0;
        last_idx_d = idx_q;
        mask_vld_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        rd_d    = '0;
        wr_d    = '0;
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      last_idx_q <= LAST_INIT;
      grant_q    <= '0;
      lba_q      <= 32'd0;
      rd_q       <= '0;
      wr_q       <= '0;
      op_rd_q    <= 1'b0;
      done_q     <= '0;
      err_q      <= '0;
      cnt_q      <= 32'd0;
      mask_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      grant_q    <= grant_d;
      lba_q      <= lba_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      op_rd_q    <= op_rd_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      mask_vld_q <= mask_vld_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.sd_lba   = lba_q;
  assign bus.sd_rd    = rd_q;
  assign bus.sd_wr    = wr_q;
  assign bus.req_done = done_q;
  assign bus.req_err  = err_q;

  // The first din strobe can precede ack, so din routing opens in WAIT_ACK
  assign bus.req_dout_strobe = grant_q & {NREQ{bus.sd_dout_strobe & (state_q == S_XFER)}};
  assign bus.req_din_strobe  = grant_q & {NREQ{bus.sd_din_strobe &
                                ((state_q == S_WAIT_ACK) || (state_q == S_XFER))}};
  assign bus.sd_din          = (grant_q != '0) ? bus.req_din[{idx_q, 3'd0} +: 8] : 8'd0;

endmodule
